// File: rtl/msrh_conf_pkg.sv
// Core-wide configuration constants shared by the LSU blocks.
package msrh_conf_pkg;
  localparam int PADDR_W       = 32;
  localparam int DCACHE_DATA_W = 128;
  localparam int STQ_SIZE      = 4;
endpackage

// File: rtl/msrh_lsu_pkg.sv
// LSU types for the committed-store drain buffer.
package msrh_lsu_pkg;
  import msrh_conf_pkg::*;

  localparam int DCACHE_LANE_B = DCACHE_DATA_W / 8;

  typedef struct packed {
    logic [PADDR_W-1:0] paddr;
    logic [63:0]        data;
    logic [7:0]         strb;
  } stq_drain_entry_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, WAIT_REFILL} stq_drain_state_t;
endpackage

// File: rtl/msrh_stq_drain_align.sv
// Places an 8-byte store word and its byte enables into its slot of a D-cache line.
module msrh_stq_drain_align #(
  parameter int DCACHE_DATA_W = 128
) (
  input  logic [$clog2(DCACHE_DATA_W/8)-4:0] i_slot,
  input  logic [63:0]                        i_data,
  input  logic [7:0]                         i_strb,
  output logic [DCACHE_DATA_W-1:0]           o_data,
  output logic [DCACHE_DATA_W/8-1:0]         o_strb
);
  assign o_data = DCACHE_DATA_W'(i_data) << {i_slot, 6'd0};
  assign o_strb = (DCACHE_DATA_W/8)'(i_strb) << {i_slot, 3'd0};
endmodule

// File: rtl/msrh_stq_drain.sv
// In-order committed-store buffer draining oldest-first into the L1D write port.
// Optional build macro MSRH_STQ_DRAIN_MERGE_EN merges same-word stores into the youngest entry.
module msrh_stq_drain
  import msrh_lsu_pkg::*;
#(
  parameter int STQ_SIZE      = msrh_conf_pkg::STQ_SIZE,
  parameter int PADDR_W       = msrh_conf_pkg::PADDR_W,
  parameter int DCACHE_DATA_W = msrh_conf_pkg::DCACHE_DATA_W
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_enq_valid,
  output logic                         o_enq_ready,
  input  logic [PADDR_W-1:0]           i_enq_paddr,
  input  logic [63:0]                  i_enq_data,
  input  logic [7:0]                   i_enq_strb,
  output logic                         o_dc_req_valid,
  input  logic                         i_dc_req_ready,
  output logic [PADDR_W-1:0]           o_dc_req_paddr,
  output logic [DCACHE_DATA_W-1:0]     o_dc_req_data,
  output logic [DCACHE_DATA_W/8-1:0]   o_dc_req_strb,
  input  logic                         i_dc_resp_valid,
  input  logic                         i_dc_resp_hit,
  input  logic                         i_dc_refill_done,
  input  logic                         i_fence_req,
  output logic                         o_fence_done,
  output logic                         o_empty,
  output logic [$clog2(STQ_SIZE):0]    o_count
);
  localparam int OFS_W = $clog2(DCACHE_DATA_W/8);
  localparam int PTR_W = $clog2(STQ_SIZE);
  localparam int CNT_W = PTR_W + 1;

  stq_drain_entry_t r_mem [STQ_SIZE];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  stq_drain_state_t r_state;
  logic             r_req_valid;

  logic [PTR_W-1:0] w_young;
  logic             w_merge;
  logic             w_enq;
  logic             w_alloc;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;
  logic [63:0]      w_merge_data;

  assign w_young = r_tail - PTR_W'(1);

`ifdef MSRH_STQ_DRAIN_MERGE_EN
  // The in-flight head must stay frozen, so it only absorbs stores while the FSM is idle.
  assign w_merge = (r_count != '0) &&
                   !((w_young == r_head) && (r_state != IDLE)) &&
                   (r_mem[w_young].paddr[PADDR_W-1:3] == i_enq_paddr[PADDR_W-1:3]);
`else
  assign w_merge = 1'b0;
`endif

  assign o_enq_ready = (r_count != CNT_W'(STQ_SIZE)) | w_merge;
  assign w_enq       = i_enq_valid & o_enq_ready;
  assign w_alloc     = w_enq & ~w_merge;
  assign w_pop       = (r_state == WAIT_RESP) & i_dc_resp_valid & i_dc_resp_hit;
  assign w_count_nxt = r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);

  always_comb begin
    w_merge_data = r_mem[w_young].data;
    for (int b = 0; b < 8; b++) begin
      if (i_enq_strb[b]) w_merge_data[b*8 +: 8] = i_enq_data[b*8 +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_alloc) begin
      r_mem[r_tail] <= '{paddr: i_enq_paddr, data: i_enq_data, strb: i_enq_strb};
    end else if (w_enq) begin
      r_mem[w_young].data <= w_merge_data;
      r_mem[w_young].strb <= r_mem[w_young].strb | i_enq_strb;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_state     <= IDLE;
      r_req_valid <= 1'b0;
    end else begin
      if (w_alloc) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)   r_head <= r_head + PTR_W'(1);
      r_count <= w_count_nxt;
      case (r_state)
        IDLE: begin
          if (r_count != '0) begin
            r_state     <= REQ;
            r_req_valid <= 1'b1;
          end
        end
        REQ: begin
          if (i_dc_req_ready) begin
            r_state     <= WAIT_RESP;
            r_req_valid <= 1'b0;
          end
        end
        WAIT_RESP: begin
          if (i_dc_resp_valid) begin
            if (!i_dc_resp_hit) begin
              r_state <= WAIT_REFILL;
            end else if (w_count_nxt != '0) begin
              r_state     <= REQ;
              r_req_valid <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        WAIT_REFILL: begin
          // Replay the retained head once the line is back.
          if (i_dc_refill_done) begin
            r_state     <= REQ;
            r_req_valid <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  msrh_stq_drain_align #(.DCACHE_DATA_W(DCACHE_DATA_W)) u_align (
    .i_slot (r_mem[r_head].paddr[OFS_W-1:3]),
    .i_data (r_mem[r_head].data),
    .i_strb (r_mem[r_head].strb),
    .o_data (o_dc_req_data),
    .o_strb (o_dc_req_strb)
  );

  assign o_dc_req_valid = r_req_valid;
  assign o_dc_req_paddr = {r_mem[r_head].paddr[PADDR_W-1:OFS_W], OFS_W'(0)};
  assign o_empty        = (r_count == '0);
  assign o_count        = r_count;
  assign o_fence_done   = i_fence_req & o_empty & (r_state == IDLE);
endmodule
